// File: rtl/emif_cal_debug_pkg.sv
// emif_cal_debug_pkg: shared states, transaction records and default widths for the cal_debug master
package emif_cal_debug_pkg;
  localparam int DEF_ADDR_WIDTH = 27;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTEEN_WIDTH = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_STAT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RDV, RESP} state_t;
  typedef struct packed {
    logic write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_BYTEEN_WIDTH-1:0] byteen;
  } cmd_t;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic timeout;
    logic was_write;
  } rsp_t;
endpackage

// File: rtl/emif_cal_debug_timer.sv
// emif_cal_debug_timer: transaction watchdog; expired pulses on the last allowed cycle, never when TIMEOUT_CYCLES is 0
module emif_cal_debug_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LIM = TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1;
  logic [CW-1:0] cnt;
  assign expired = TIMEOUT_CYCLES != 0 && enable && cnt == CW'(LIM);
  always_ff @(posedge clk)
    cnt <= (rst || clear) ? '0 : enable ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/emif_cal_debug_master.sv
// emif_cal_debug_master: single-outstanding Avalon-MM master bridging a command stream onto the IOSSM cal_debug port
module emif_cal_debug_master
  import emif_cal_debug_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTEEN_WIDTH = DEF_BYTEEN_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
  input  logic                    cal_debug_clk,
  input  logic                    cal_debug_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [BYTEEN_WIDTH-1:0] cmd_byteen,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_timeout,
  output logic                    rsp_was_write,
  output logic                    cal_debug_read,
  output logic                    cal_debug_write,
  output logic [ADDR_WIDTH-1:0]   cal_debug_addr,
  output logic [DATA_WIDTH-1:0]   cal_debug_write_data,
  output logic [BYTEEN_WIDTH-1:0] cal_debug_byteenable,
  input  logic                    cal_debug_waitrequest,
  input  logic [DATA_WIDTH-1:0]   cal_debug_read_data,
  input  logic                    cal_debug_read_data_valid,
  input  logic                    stat_clear,
  output logic [STAT_WIDTH-1:0]   timeout_count,
  output logic                    err_spurious,
  output logic                    busy
);
  state_t state;
  logic expired, rd_ok, spurious, done;
  logic [STAT_WIDTH-1:0] tc_next;
  assign busy = state != IDLE;
  assign rd_ok = state == REQ && cal_debug_read && !cal_debug_waitrequest;
  assign spurious = cal_debug_read_data_valid && !(state == WAIT_RDV || rd_ok);
  assign done = cal_debug_write || cal_debug_read_data_valid;
  assign tc_next = timeout_count + STAT_WIDTH'(!(&timeout_count));
  emif_cal_debug_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(cal_debug_clk),
    .rst(cal_debug_reset),
    .clear(state == IDLE),
    .enable(state == REQ || state == WAIT_RDV),
    .expired(expired)
  );
  always_ff @(posedge cal_debug_clk) begin
    if (cal_debug_reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_timeout <= 1'b0;
      rsp_was_write <= 1'b0;
      cal_debug_read <= 1'b0;
      cal_debug_write <= 1'b0;
      cal_debug_addr <= '0;
      cal_debug_write_data <= '0;
      cal_debug_byteenable <= '0;
      timeout_count <= '0;
      err_spurious <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state <= REQ;
          cmd_ready <= 1'b0;
          cal_debug_read <= !cmd_write;
          cal_debug_write <= cmd_write;
          cal_debug_addr <= cmd_addr;
          cal_debug_write_data <= cmd_wdata;
          cal_debug_byteenable <= cmd_byteen;
          rsp_was_write <= cmd_write;
        end
        REQ: if (!cal_debug_waitrequest) begin
          cal_debug_read <= 1'b0;
          cal_debug_write <= 1'b0;
          rsp_timeout <= 1'b0;
          rsp_rdata <= cal_debug_read ? cal_debug_read_data : '0;
          rsp_valid <= done;
          state <= done ? RESP : WAIT_RDV;
        end else if (expired) begin
          cal_debug_read <= 1'b0;
          cal_debug_write <= 1'b0;
          rsp_timeout <= 1'b1;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state <= RESP;
          timeout_count <= tc_next;
        end
        WAIT_RDV: if (cal_debug_read_data_valid || expired) begin
          rsp_timeout <= !cal_debug_read_data_valid;
          rsp_rdata <= cal_debug_read_data_valid ? cal_debug_read_data : '0;
          rsp_valid <= 1'b1;
          state <= RESP;
          if (!cal_debug_read_data_valid) timeout_count <= tc_next;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (spurious) err_spurious <= 1'b1;
      if (stat_clear) begin
        timeout_count <= '0;
        err_spurious <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_emif_cal_debug_master.sv
// tb_emif_cal_debug_master: scoreboard bench driving commands against a behavioural cal_debug slave
module tb_emif_cal_debug_master;
  logic cal_debug_clk = 1'b0;
  logic cal_debug_reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [26:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_byteen = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, rsp_was_write;
  logic [31:0] rsp_rdata;
  logic cal_debug_read, cal_debug_write;
  logic [26:0] cal_debug_addr;
  logic [31:0] cal_debug_write_data;
  logic [3:0] cal_debug_byteenable;
  logic cal_debug_waitrequest = 1'b0;
  logic [31:0] cal_debug_read_data = '0;
  logic cal_debug_read_data_valid = 1'b0;
  logic stat_clear = 1'b0;
  logic [15:0] timeout_count;
  logic err_spurious, busy;
  typedef struct packed {logic w; logic to; logic [31:0] d;} exp_t;
  exp_t sbq[$];
  logic [31:0] smem [logic [26:0]];
  logic [31:0] ref_mem [logic [26:0]];
  int total = 0, bad = 0;
  logic both_seen = 1'b0;
  emif_cal_debug_master #(.TIMEOUT_CYCLES(16)) dut (
    .cal_debug_clk(cal_debug_clk),
    .cal_debug_reset(cal_debug_reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_byteen(cmd_byteen),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .rsp_was_write(rsp_was_write),
    .cal_debug_read(cal_debug_read),
    .cal_debug_write(cal_debug_write),
    .cal_debug_addr(cal_debug_addr),
    .cal_debug_write_data(cal_debug_write_data),
    .cal_debug_byteenable(cal_debug_byteenable),
    .cal_debug_waitrequest(cal_debug_waitrequest),
    .cal_debug_read_data(cal_debug_read_data),
    .cal_debug_read_data_valid(cal_debug_read_data_valid),
    .stat_clear(stat_clear),
    .timeout_count(timeout_count),
    .err_spurious(err_spurious),
    .busy(busy)
  );
  always #5 cal_debug_clk = ~cal_debug_clk;
  always @(negedge cal_debug_clk) if (cal_debug_read && cal_debug_write) both_seen = 1'b1;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] sval(input logic [26:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction
  task automatic txn(input logic w, input logic [26:0] a, input logic [31:0] d, input logic [3:0] be,
                     input int ws, input int lat, input int hold);
    exp_t e;
    logic [31:0] old, cap_d, p_d;
    logic [26:0] cap_a;
    logic stable, p_to, p_w;
    int n, i, exp_req;
    e.w = w;
    e.to = ws >= 16;
    old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    if (w) ref_mem[a] = merge(old, d, be);
    e.d = (w || e.to) ? 32'h0 : old;
    exp_req = e.to ? 16 : ws + 1;
    sbq.push_back(e);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_byteen = be;
    @(negedge cal_debug_clk);
    cmd_valid = 1'b0;
    cap_a = cal_debug_addr;
    cap_d = cal_debug_write_data;
    chk("req_kind", {cal_debug_read, cal_debug_write}, {!w, w});
    chk("req_addr", cal_debug_addr, a);
    chk("req_be", cal_debug_byteenable, be);
    if (w) chk("req_wdata", cal_debug_write_data, d);
    n = 0; i = 0; stable = 1'b1;
    while ((cal_debug_read || cal_debug_write) && i < 100) begin
      n++;
      if (cal_debug_addr !== cap_a || cal_debug_write_data !== cap_d || cal_debug_read !== !w) stable = 1'b0;
      cal_debug_waitrequest = i < ws;
      if (!cal_debug_waitrequest && w) smem[cal_debug_addr] = merge(sval(cal_debug_addr), cal_debug_write_data, cal_debug_byteenable);
      if (!cal_debug_waitrequest && !w && lat == 0) begin
        cal_debug_read_data_valid = 1'b1;
        cal_debug_read_data = sval(cap_a);
      end
      i++;
      @(negedge cal_debug_clk);
    end
    cal_debug_waitrequest = 1'b0;
    cal_debug_read_data_valid = 1'b0;
    chk("req_cycles", n, exp_req);
    chk("req_stable", stable, 1);
    if (!w && !e.to && lat > 0) begin
      repeat (lat - 1) @(negedge cal_debug_clk);
      cal_debug_read_data_valid = 1'b1;
      cal_debug_read_data = sval(cap_a);
      @(negedge cal_debug_clk);
      cal_debug_read_data_valid = 1'b0;
    end
    i = 0;
    while (!rsp_valid && i < 50) begin
      @(negedge cal_debug_clk);
      i++;
    end
    chk("rsp_seen", rsp_valid, 1);
    chk("sb_nonempty", sbq.size() != 0, 1);
    e = sbq.pop_front();
    if (rsp_valid) begin
      p_d = rsp_rdata; p_to = rsp_timeout; p_w = rsp_was_write; stable = 1'b1;
      repeat (hold) begin
        @(negedge cal_debug_clk);
        if (!rsp_valid || rsp_rdata !== p_d || rsp_timeout !== p_to || rsp_was_write !== p_w ||
            cmd_ready || cal_debug_read || cal_debug_write) stable = 1'b0;
      end
      if (hold > 0) chk("rsp_hold", stable, 1);
      chk("rsp_rdata", rsp_rdata, e.d);
      chk("rsp_timeout", rsp_timeout, e.to);
      chk("rsp_was_write", rsp_was_write, e.w);
      rsp_ready = 1'b1;
      @(negedge cal_debug_clk);
      rsp_ready = 1'b0;
      chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
    end
  endtask
  initial begin
    logic [26:0] pick [4];
    pick[0] = 27'h40; pick[1] = 27'h1000; pick[2] = 27'h200; pick[3] = 27'h300;
    smem[27'h40] = 32'h12345678;
    ref_mem[27'h40] = 32'h12345678;
    repeat (3) @(negedge cal_debug_clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outs", {rsp_valid, cal_debug_read, cal_debug_write, busy, err_spurious, rsp_timeout}, 0);
    chk("rst_tcount", timeout_count, 0);
    cal_debug_reset = 1'b0;
    @(negedge cal_debug_clk);
    txn(1'b1, 27'h0001000, 32'hA5A5A5A5, 4'hF, 3, 0, 0);
    txn(1'b0, 27'h0000040, 32'h0, 4'hF, 0, 5, 0);
    chk("tcount_zero", timeout_count, 0);
    txn(1'b0, 27'h0000100, 32'h0, 4'hF, 1000, 0, 0);
    chk("tcount_one", timeout_count, 1);
    chk("spur_clean", err_spurious, 0);
    cal_debug_read_data_valid = 1'b1;
    cal_debug_read_data = 32'hDEAD0000;
    @(negedge cal_debug_clk);
    cal_debug_read_data_valid = 1'b0;
    chk("spur_late_rdv", err_spurious, 1);
    stat_clear = 1'b1;
    @(negedge cal_debug_clk);
    stat_clear = 1'b0;
    chk("stat_clear", {timeout_count, err_spurious}, 0);
    txn(1'b1, 27'h0000040, 32'hCAFEF00D, 4'h3, 0, 0, 10);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 27'h80; cmd_byteen = 4'hF;
    @(negedge cal_debug_clk);
    cmd_valid = 1'b0;
    @(negedge cal_debug_clk);
    chk("wait_rdv_state", {busy, cal_debug_read, rsp_valid}, 3'b100);
    cal_debug_reset = 1'b1;
    @(negedge cal_debug_clk);
    chk("rst_mid_rw", {cal_debug_read, cal_debug_write, cal_debug_byteenable}, 0);
    chk("rst_mid_bus", {cal_debug_addr, cal_debug_write_data}, 0);
    chk("rst_mid_ctl", {cmd_ready, busy, rsp_valid}, 3'b100);
    cal_debug_reset = 1'b0;
    txn(1'b0, 27'h0000040, 32'h0, 4'hF, 0, 2, 0);
    for (int k = 0; k < 8; k++)
      txn(1'($urandom_range(0, 1)), pick[$urandom_range(0, 3)], $urandom, 4'($urandom_range(1, 15)),
          $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
    chk("never_both", both_seen, 0);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
